// File: rtl/pcm_sched_pkg.sv
// Shared types and helpers for the PCM FIR scheduler.
package pcm_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Channel index width; a single channel still gets one bit so ports never collapse
    function automatic int chw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sign-extend the low w bits of v to 32 bits; callers truncate to their own width
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = $signed(v << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/pcm_sched_pick.sv
// Lowest-set-bit priority encoder: picks the next channel to hand to the FIR.
module pcm_sched_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    output logic [CHW-1:0] idx,
    output logic           found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = CHW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_fir_sched.sv
// Time-multiplexes one shared FIR engine across NCH decimated microphone channels.
//
//   state | meaning
//   IDLE  | no FIR job in flight; issue the lowest pending channel if any
//   WAIT  | FIR busy with cur_ch, waiting for fir_done
//   OUT   | result held on the output stream until out_ready
module pcm_fir_sched
    import pcm_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W_CIC = 12,
    parameter int W_FIR = 16,
    localparam int CHW  = chw_of(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NCH-1:0]       ch_mask,
    input  logic                 ce_pcm,
    input  logic [NCH*W_CIC-1:0] cic_data,
    output logic                 fir_start,
    output logic [CHW-1:0]       fir_ch,
    output logic [W_FIR-1:0]     fir_in,
    input  logic                 fir_done,
    input  logic [W_FIR-1:0]     fir_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_FIR-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    state_t             state_q, state_d;
    logic [NCH-1:0]     pending_q;
    logic [W_CIC-1:0]   hold_q [NCH];
    logic [CHW-1:0]     cur_ch_q;
    logic [W_FIR-1:0]   fir_in_q;
    logic [CHW-1:0]     sel;
    logic               found;
    logic [W_FIR-1:0]   sel_ext;
    logic               capture;
    logic               issue;

    // A frame strobe with nothing enabled is a no-op rather than an empty capture
    assign capture = ce_pcm && enable && (|ch_mask);
    assign issue   = (state_q == IDLE) && found;
    assign sel_ext = W_FIR'(sext(32'(hold_q[sel]), W_CIC));

    pcm_sched_pick #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_pick (
        .req   (pending_q),
        .idx   (sel),
        .found (found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; FIR latency is unbounded so WAIT has no timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)     state_d = WAIT;
            WAIT:    if (fir_done)  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FIR request outputs; channel/sample hold their last issued value between requests
    always_comb begin
        fir_start = issue;
        fir_ch    = issue ? sel     : cur_ch_q;
        fir_in    = issue ? sel_ext : fir_in_q;
        busy      = (state_q != IDLE) || (|pending_q);
    end

    // Snapshot enabled CIC outputs on the frame strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < NCH; k++)
                if (ch_mask[k]) hold_q[k] <= cic_data[k*W_CIC +: W_CIC];
        end
    end

    // Pending vector: a new frame overwrites, disabling flushes, issuing retires one bit
    always_ff @(posedge clk) begin
        if (rst)           pending_q <= '0;
        else if (capture)  pending_q <= ch_mask;
        else if (!enable)  pending_q <= '0;
        else if (issue)    pending_q <= pending_q & ~(NCH'(1) << sel);
    end

    // Remember which channel and sample went to the FIR
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch_q <= '0;
            fir_in_q <= '0;
        end else if (issue) begin
            cur_ch_q <= sel;
            fir_in_q <= sel_ext;
        end
    end

    // Result stream register; only a completion seen in WAIT is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (state_q == WAIT && fir_done) begin
            out_valid <= 1'b1;
            out_data  <= fir_out;
            out_ch    <= cur_ch_q;
        end else if (state_q == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a new frame arriving before the last one drained wins over a clear
    always_ff @(posedge clk) begin
        if (rst)                         overrun <= 1'b0;
        else if (capture && |pending_q)  overrun <= 1'b1;
        else if (clr_overrun)            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_pcm_fir_sched.sv
// Bench for pcm_fir_sched: FIR stub, transaction-level reference model, directed + random stimulus.
module tb_pcm_fir_sched;

    localparam int NCH = 4, W_CIC = 12, W_FIR = 16, CHW = 2;

    logic clk = 1'b0;
    logic rst, enable, ce_pcm, fir_done, out_ready, clr_overrun;
    logic [NCH-1:0]       ch_mask;
    logic [NCH*W_CIC-1:0] cic_data;
    logic [W_FIR-1:0]     fir_out;
    logic                 fir_start, out_valid, overrun, busy;
    logic [CHW-1:0]       fir_ch, out_ch;
    logic [W_FIR-1:0]     fir_in, out_data;

    always #5 clk = ~clk;

    pcm_fir_sched #(.NCH(NCH), .W_CIC(W_CIC), .W_FIR(W_FIR)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .ce_pcm(ce_pcm),
        .cic_data(cic_data), .fir_start(fir_start), .fir_ch(fir_ch), .fir_in(fir_in),
        .fir_done(fir_done), .fir_out(fir_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .overrun(overrun), .clr_overrun(clr_overrun),
        .busy(busy)
    );

    typedef struct { logic [1:0] ch; logic [15:0] data; } res_t;

    int checks = 0, failures = 0, cyc = 0;

    // reference model: what has been captured, what is owed, what the stream must show
    logic [3:0]  m_pend;
    logic [11:0] m_hold [4];
    logic        m_ovr, m_inflight;
    logic [1:0]  m_ch;
    res_t        exp_q[$];

    // FIR stub
    int          stub_cnt = 0, lat = 3;
    bit          echo = 1'b1;
    logic [15:0] stub_val;

    int   start_log[$], hs_log[$];
    res_t got_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] sx(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    // one clock cycle: check this cycle's outputs against the model, advance model, clock, run stub
    task automatic tick();
        logic [3:0] pend_reg;
        bit         exp_start, exp_valid, exp_busy, cap, set_ovr;
        int         lo;
        pend_reg  = m_pend;
        exp_valid = (exp_q.size() != 0);
        exp_start = !m_inflight && !exp_valid && (m_pend != 0);
        exp_busy  = m_inflight || exp_valid || (m_pend != 0);

        chk("fir_start", 32'(fir_start), 32'(exp_start));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (exp_valid) begin
            chk("out_ch", 32'(out_ch), 32'(exp_q[0].ch));
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
        end

        if (fir_done && m_inflight) begin
            exp_q.push_back('{ch: m_ch, data: fir_out});
            m_inflight = 1'b0;
        end
        if (exp_start) begin
            lo = lowest(m_pend);
            chk("fir_ch", 32'(fir_ch), 32'(lo));
            chk("fir_in", 32'(fir_in), 32'(sx(m_hold[lo])));
            m_pend[lo] = 1'b0;
            m_ch       = 2'(lo);
            m_inflight = 1'b1;
        end
        if (fir_start) begin
            start_log.push_back(cyc);
            stub_cnt = lat + 1;
            stub_val = echo ? fir_in : 16'($urandom);
        end
        if (exp_valid && out_ready) begin
            got_log.push_back('{ch: out_ch, data: out_data});
            hs_log.push_back(cyc);
            void'(exp_q.pop_front());
        end

        cap     = ce_pcm && enable && (ch_mask != 0);
        set_ovr = cap && (pend_reg != 0);
        if (set_ovr)          m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        if (cap) begin
            m_pend = ch_mask;
            for (int k = 0; k < 4; k++) if (ch_mask[k]) m_hold[k] = cic_data[k*12 +: 12];
        end else if (!enable) begin
            m_pend = 4'b0;
        end
        if (rst) begin
            m_pend = 4'b0; m_ovr = 1'b0; m_inflight = 1'b0; exp_q.delete();
            for (int k = 0; k < 4; k++) m_hold[k] = 12'h0;
        end

        @(posedge clk); #1;
        cyc++;
        fir_done = 1'b0;
        fir_out  = 16'($urandom);
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin fir_done = 1'b1; fir_out = stub_val; end
        end
    endtask

    task automatic pulse_ce();
        ce_pcm = 1'b1; tick(); ce_pcm = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk(tag, 32'(busy), 32'(0));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin tick(); n++; end
        chk(tag, 32'(out_valid), 32'(1));
    endtask

    task automatic clear_logs();
        start_log.delete(); hs_log.delete(); got_log.delete();
    endtask

    initial begin : main
        int          c0, hs_c, n;
        logic [15:0] d_hold;
        logic [1:0]  ch_hold;
        logic [15:0] t1_exp [4];
        t1_exp = '{16'h07FF, 16'hF800, 16'h0001, 16'hFFFF};

        rst = 1'b1; enable = 1'b0; ce_pcm = 1'b0; ch_mask = '0; cic_data = '0;
        fir_done = 1'b0; fir_out = '0; out_ready = 1'b1; clr_overrun = 1'b0;
        m_pend = '0; m_ovr = 1'b0; m_inflight = 1'b0; m_ch = '0;
        for (int k = 0; k < 4; k++) m_hold[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_fir_start", 32'(fir_start), 32'(0));
        tick();

        // 1: basic frame
        enable = 1'b1; ch_mask = 4'hF; lat = 3; echo = 1'b1;
        cic_data = {12'hFFF, 12'h001, 12'h800, 12'h7FF};
        clear_logs(); c0 = cyc;
        pulse_ce();
        wait_idle("t1_idle", 100);
        chk("t1_nstart", 32'(start_log.size()), 32'(4));
        chk("t1_nout", 32'(got_log.size()), 32'(4));
        if (start_log.size() > 0) chk("t1_first_start", 32'(start_log[0]), 32'(c0 + 1));
        for (int i = 1; i < start_log.size(); i++)
            chk("t1_start_period", 32'(start_log[i] - start_log[i-1]), 32'(6));
        for (int i = 1; i < hs_log.size(); i++)
            chk("t1_out_period", 32'(hs_log[i] - hs_log[i-1]), 32'(6));
        for (int i = 0; i < got_log.size() && i < 4; i++) begin
            chk("t1_ch", 32'(got_log[i].ch), 32'(i));
            chk("t1_data", 32'(got_log[i].data), 32'(t1_exp[i]));
        end

        // 2: backpressure on ch0
        cic_data = {NCH{12'($urandom)}};
        cic_data[23:12] = 12'($urandom);
        out_ready = 1'b0; clear_logs();
        pulse_ce();
        wait_valid("t2_valid", 50);
        d_hold = out_data; ch_hold = out_ch;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 32'(1));
            chk("t2_hold_data", 32'(out_data), 32'(d_hold));
            chk("t2_hold_ch", 32'(out_ch), 32'(ch_hold));
            chk("t2_no_start", 32'(fir_start), 32'(0));
        end
        out_ready = 1'b1; hs_c = cyc;
        tick(); tick();
        chk("t2_nstart", 32'(start_log.size()), 32'(2));
        if (start_log.size() > 1) chk("t2_ch1_start", 32'(start_log[1]), 32'(hs_c + 1));
        wait_idle("t2_idle", 100);

        // 3: overrun
        lat = 5; cic_data = {$urandom, $urandom};
        pulse_ce();
        repeat (7) tick();
        pulse_ce();
        chk("t3_overrun_set", 32'(overrun), 32'(1));
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        chk("t3_overrun_clr", 32'(overrun), 32'(0));
        repeat (6) tick();
        clr_overrun = 1'b1; pulse_ce(); clr_overrun = 1'b0;
        chk("t3_overrun_set_wins", 32'(overrun), 32'(1));
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        wait_idle("t3_idle", 400);

        // 4: channel mask
        lat = 3; ch_mask = 4'b0101; clear_logs();
        pulse_ce();
        wait_idle("t4_idle", 100);
        chk("t4_nout", 32'(got_log.size()), 32'(2));
        if (got_log.size() == 2) begin
            chk("t4_first_ch", 32'(got_log[0].ch), 32'(0));
            chk("t4_second_ch", 32'(got_log[1].ch), 32'(2));
        end
        if (hs_log.size() > 0) chk("t4_busy_fall", 32'(cyc), 32'(hs_log[hs_log.size()-1] + 1));

        // 5: reset mid-WAIT
        ch_mask = 4'hF; clear_logs();
        pulse_ce();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 32'(0));
        chk("t5_fir_start", 32'(fir_start), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_out", 32'(out_valid), 32'(0));
        end

        // 6: enable drop while ch1 is in WAIT
        clear_logs(); n = 0;
        pulse_ce();
        while (start_log.size() < 2 && n < 50) begin tick(); n++; end
        chk("t6_ch1_issued", 32'(start_log.size()), 32'(2));
        tick();
        enable = 1'b0;
        tick();
        pulse_ce();
        wait_idle("t6_idle", 100);
        chk("t6_nstart", 32'(start_log.size()), 32'(2));
        chk("t6_nout", 32'(got_log.size()), 32'(2));
        if (got_log.size() == 2) chk("t6_last_ch", 32'(got_log[1].ch), 32'(1));
        if (hs_log.size() > 0) chk("t6_busy_fall", 32'(cyc), 32'(hs_log[hs_log.size()-1] + 1));
        enable = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ce_pcm      = ($urandom_range(0, 15) == 0);
            ch_mask     = 4'($urandom);
            cic_data    = {$urandom, $urandom};
            out_ready   = ($urandom_range(0, 3) != 0);
            enable      = ($urandom_range(0, 40) != 0);
            clr_overrun = ($urandom_range(0, 25) == 0);
            rst         = ($urandom_range(0, 400) == 0);
            echo        = 1'($urandom);
            if (stub_cnt == 0) lat = $urandom_range(0, 4);
            tick();
        end
        ce_pcm = 1'b0; rst = 1'b0; clr_overrun = 1'b0; out_ready = 1'b1; enable = 1'b1;
        wait_idle("final_idle", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
